// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
package shifter_pkg;
  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;
endpackage

// File: rtl/shift_stage.sv
// One combinational level of the barrel shifter: shifts by the constant DIST when en_i is set.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_e        op_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted;

  // ASR fill uses the current MSB, which earlier levels have already kept equal to the operand sign.
  always_comb begin
    shifted = data_i;
    case (op_i)
      OP_LSL: shifted = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
      OP_LSR: shifted = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
      OP_ASR: shifted = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
      OP_ROR: shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
    endcase
  end

  assign data_o = en_i ? shifted : data_i;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, largest distance first,
// with a single global advance that stalls every stage together under output backpressure.
module barrel_shift_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [OP_W-1:0]   in_op,
  input  logic [SHW-1:0]    in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_zero
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || SHW != $clog2(WIDTH)) begin : g_bad_params
    $error("barrel_shift_pipe: WIDTH must be a power of two >= 4 and SHW must be $clog2(WIDTH)");
  end

  logic             advance;

  // Intermediate stage registers 0..SHW-2; the last stage lands in the out_* registers.
  logic             vld_q  [SHW-1];
  logic [WIDTH-1:0] data_q [SHW-1];
  shift_op_e        op_q   [SHW-1];
  logic [SHW-1:0]   amt_q  [SHW-1];

  logic             s_vld  [SHW];
  logic [WIDTH-1:0] s_data [SHW];
  shift_op_e        s_op   [SHW];
  logic [SHW-1:0]   s_amt  [SHW];
  logic [WIDTH-1:0] data_d [SHW];

  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;

  assign advance = !out_vld_q || out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign s_vld[k]  = in_valid;
      assign s_data[k] = in_data;
      assign s_op[k]   = shift_op_e'(in_op);
      assign s_amt[k]  = in_amt;
    end else begin : g_next
      assign s_vld[k]  = vld_q[k-1];
      assign s_data[k] = data_q[k-1];
      assign s_op[k]   = op_q[k-1];
      assign s_amt[k]  = amt_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** (SHW - 1 - k))
    ) u_shift (
      .data_i (s_data[k]),
      .op_i   (s_op[k]),
      .en_i   (s_amt[k][SHW-1-k]),
      .data_o (data_d[k])
    );
  end

  // Stage boundary: valid bits and the visible output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SHW - 1; k++) vld_q[k] <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SHW - 1; k++) vld_q[k] <= s_vld[k];
      out_vld_q  <= s_vld[SHW-1];
      out_data_q <= data_d[SHW-1];
      out_zero_q <= (data_d[SHW-1] == '0);
    end
  end

  // Stage boundary: intermediate payload, qualified by vld_q.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < SHW - 1; k++) begin
        data_q[k] <= data_d[k];
        op_q[k]   <= s_op[k];
        amt_q[k]  <= s_amt[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;

endmodule
